alu_acc_ctrl: RTL

Sequential front end for the combinational ALU. It accepts operation commands over a valid/ready handshake and drives the ALU operand and op inputs from an internal accumulator and the command operand. It captures the ALU result and zero/carry flags into registers. It is the initiator side of the ALU interface: the block that owns and drives x/y/op and consumes r/fz/fc, replacing bench stimulus in the datapath.

---
 rtl/alu_acc_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_acc_ctrl.sv
// Command front end for the combinational ALU: accepts commands on a valid/ready
// handshake, drives x/y/op from registers and retires results into acc/fz/fc.
module alu_acc_ctrl #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_type_i,
    input  logic [OPW-1:0]   cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    output logic [WIDTH-1:0] alu_x_o,
    output logic [WIDTH-1:0] alu_y_o,
    output logic [OPW-1:0]   alu_op_o,
    input  logic [WIDTH-1:0] alu_r_i,
    input  logic             alu_fz_i,
    input  logic             alu_fc_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             fz_o,
    output logic             fc_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    localparam logic [1:0] CMD_ALU  = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_CMP  = 2'b10;
    localparam logic [1:0] CMD_CLRF = 2'b11;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         type_r;
    logic [OPW-1:0]     op_r;
    logic [WIDTH-1:0]   y_r;
    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   acc_r;
    logic               fz_r;
    logic               fc_r;
    logic               done_r;
    logic               ready_r;
    logic               accept_s;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic               fz_nxt_s;
    logic               fc_nxt_s;

    // Next-state decode and per-type result selection at the end of EXEC.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        acc_nxt_s   = acc_r;
        fz_nxt_s    = fz_r;
        fc_nxt_s    = fc_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i && ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_WB;
                case (type_r)
                    CMD_ALU: begin
                        acc_nxt_s = alu_r_i;
                        fz_nxt_s  = alu_fz_i;
                        fc_nxt_s  = alu_fc_i;
                    end
                    CMD_LOAD: begin
                        acc_nxt_s = y_r;
                    end
                    CMD_CMP: begin
                        fz_nxt_s = alu_fz_i;
                        fc_nxt_s = alu_fc_i;
                    end
                    CMD_CLRF: begin
                        fz_nxt_s = 1'b0;
                        fc_nxt_s = 1'b0;
                    end
                    default: begin
                        acc_nxt_s = acc_r;
                    end
                endcase
            end
            ST_WB: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, command latches and result registers; reset drops any in-flight command.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            type_r  <= 2'b00;
            op_r    <= {OPW{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            x_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            fz_r    <= 1'b0;
            fc_r    <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            done_r  <= (state_nxt_s == ST_WB);
            acc_r   <= acc_nxt_s;
            fz_r    <= fz_nxt_s;
            fc_r    <= fc_nxt_s;
            if (accept_s) begin
                type_r <= cmd_type_i;
                op_r   <= cmd_op_i;
                y_r    <= cmd_data_i;
                // acc is final while idle, so a snapshot here equals acc during EXEC
                x_r    <= acc_r;
            end
        end
    end

    assign cmd_ready_o = ready_r;
    assign alu_x_o     = x_r;
    assign alu_y_o     = y_r;
    assign alu_op_o    = op_r;
    assign acc_o       = acc_r;
    assign fz_o        = fz_r;
    assign fc_o        = fc_r;
    assign done_o      = done_r;

endmodule
